// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchroniser, 16x oversampling, mid-bit sampling, 5-8 data bits, optional parity, 1/2 stop bits.
// Optional break detection is compiled in when UART_RX_BREAK_DET_EN is defined.
module uart_rx #(
  parameter int BAUD_RATE     = 115200,
  parameter int FREQUENCY_CLK = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy,
  output logic       break_det
);

  localparam int DIV = FREQUENCY_CLK / (BAUD_RATE * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [3:0]    SAMPLE_IDX = 4'd7;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BIT,
    PARITY_BIT,
    STOP_BIT_FIRST,
    STOP_BIT_SECOND
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_sync_q;
  logic          armed_q, armed_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    tcnt_q, tcnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_acc_q, par_acc_d;
  logic          stop_err_q, stop_err_d;
  logic [1:0]    cfg_dbn_q, cfg_dbn_d;
  logic          cfg_stop2_q, cfg_stop2_d;
  logic          cfg_pen_q, cfg_pen_d;
  logic          cfg_even_q, cfg_even_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_done_q, rx_done_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          tick, sample, fin, fin_ferr;
`ifdef UART_RX_BREAK_DET_EN
  logic          zero_q, zero_d;
  logic          brk_q, brk_d;
`endif

  // LSB arrives first and is shifted in from the top, so short words sit high.
  function automatic logic [7:0] align_data(input logic [7:0] sh, input logic [1:0] dbn);
    logic [1:0] amt;
    amt = 2'd3 - dbn;
    return sh >> amt;
  endfunction

  function automatic logic parity_fail(input logic acc, input logic even);
    return even ? acc : ~acc;
  endfunction

  assign tick   = (div_q == DIV_LAST);
  assign sample = tick && (tcnt_q == SAMPLE_IDX);

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    div_d        = tick ? '0 : div_q + DW'(1);
    tcnt_d       = tick ? tcnt_q + 4'd1 : tcnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    par_acc_d    = par_acc_q;
    stop_err_d   = stop_err_q;
    cfg_dbn_d    = cfg_dbn_q;
    cfg_stop2_d  = cfg_stop2_q;
    cfg_pen_d    = cfg_pen_q;
    cfg_even_d   = cfg_even_q;
    rx_data_d    = rx_data_q;
    rx_done_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    fin          = 1'b0;
    fin_ferr     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    zero_d       = zero_q;
    brk_d        = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        armed_d = armed_q | rx_sync_q;
        if (armed_q && !rx_sync_q) begin
          state_d     = START_BIT;
          armed_d     = 1'b0;
          div_d       = '0;
          tcnt_d      = '0;
          bit_idx_d   = '0;
          par_acc_d   = 1'b0;
          stop_err_d  = 1'b0;
          cfg_dbn_d   = data_bit_num;
          cfg_stop2_d = stop_bit_num;
          cfg_pen_d   = parity_en;
          cfg_even_d  = parity_type;
`ifdef UART_RX_BREAK_DET_EN
          zero_d      = 1'b1;
`endif
        end
      end
      START_BIT: begin
        if (sample) state_d = rx_sync_q ? IDLE : DATA_BIT;
      end
      DATA_BIT: begin
        if (sample) begin
          shreg_d   = {rx_sync_q, shreg_q[7:1]};
          par_acc_d = par_acc_q ^ rx_sync_q;
`ifdef UART_RX_BREAK_DET_EN
          zero_d    = zero_q & ~rx_sync_q;
`endif
          if (bit_idx_q == 3'd4 + {1'b0, cfg_dbn_q}) begin
            state_d = cfg_pen_q ? PARITY_BIT : STOP_BIT_FIRST;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY_BIT: begin
        if (sample) begin
          par_acc_d = par_acc_q ^ rx_sync_q;
`ifdef UART_RX_BREAK_DET_EN
          zero_d    = zero_q & ~rx_sync_q;
`endif
          state_d   = STOP_BIT_FIRST;
        end
      end
      STOP_BIT_FIRST: begin
        if (sample) begin
`ifdef UART_RX_BREAK_DET_EN
          zero_d = zero_q & ~rx_sync_q;
`endif
          if (cfg_stop2_q) begin
            stop_err_d = ~rx_sync_q;
            state_d    = STOP_BIT_SECOND;
          end else begin
            fin      = 1'b1;
            fin_ferr = ~rx_sync_q;
          end
        end
      end
      STOP_BIT_SECOND: begin
        if (sample) begin
          fin      = 1'b1;
          fin_ferr = stop_err_q | ~rx_sync_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame ends at the final stop sample; re-arm waits for the line to be seen high.
    if (fin) begin
      state_d      = IDLE;
      armed_d      = 1'b0;
      rx_data_d    = align_data(shreg_q, cfg_dbn_q);
      parity_err_d = cfg_pen_q & parity_fail(par_acc_q, cfg_even_q);
      frame_err_d  = fin_ferr;
      rx_done_d    = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
      brk_d        = zero_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      armed_q      <= 1'b0;
      div_q        <= '0;
      tcnt_q       <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      par_acc_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      cfg_dbn_q    <= '0;
      cfg_stop2_q  <= 1'b0;
      cfg_pen_q    <= 1'b0;
      cfg_even_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      zero_q       <= 1'b0;
      brk_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      armed_q      <= armed_d;
      div_q        <= div_d;
      tcnt_q       <= tcnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      par_acc_q    <= par_acc_d;
      stop_err_q   <= stop_err_d;
      cfg_dbn_q    <= cfg_dbn_d;
      cfg_stop2_q  <= cfg_stop2_d;
      cfg_pen_q    <= cfg_pen_d;
      cfg_even_q   <= cfg_even_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_BREAK_DET_EN
      zero_q       <= zero_d;
      brk_q        <= brk_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_done    = rx_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != IDLE);
`ifdef UART_RX_BREAK_DET_EN
  assign break_det  = brk_q;
`else
  assign break_det  = 1'b0;
`endif

endmodule
